// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard sources in, pipeline-register controls
// and performance counters out.
interface hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH      = 32
);
   logic [REG_ADDR_WIDTH-1:0] id_rs1;
   logic [REG_ADDR_WIDTH-1:0] id_rs2;
   logic                      id_uses_rs1;
   logic                      id_uses_rs2;
   logic [REG_ADDR_WIDTH-1:0] ex_rd;
   logic                      ex_mem_read;
   logic                      ex_redirect;
   logic                      mem_req;
   logic                      mem_ready;
   logic                      pc_write_en;
   logic                      ifid_stall;
   logic                      ifid_flush;
   logic                      idex_stall;
   logic                      idex_flush;
   logic                      exmem_stall;
   logic                      mem_timeout;
   logic [CNT_WIDTH-1:0]      stall_cycles;
   logic [CNT_WIDTH-1:0]      flush_events;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ready,
      input  pc_write_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, mem_timeout, stall_cycles, flush_events
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_redirect, mem_req, mem_ready,
      output pc_write_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, mem_timeout, stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: load-use bubbles, EX redirects, data-memory
// wait stalls with a sticky timeout fault, plus stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned MEM_TIMEOUT    = 256
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [WAIT_W-1:0]    w_wait_nxt;
   logic [CNT_WIDTH-1:0] r_stall_cycles;
   logic [CNT_WIDTH-1:0] r_flush_events;

   logic w_memwait;
   logic w_loaduse;
   logic w_pc_we;
   logic w_ifid_stall;
   logic w_ifid_flush;
   logic w_idex_stall;
   logic w_idex_flush;
   logic w_exmem_stall;
   logic w_timeout;

   assign w_memwait = hz.mem_req & ~hz.mem_ready;
   assign w_loaduse = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // wait_cnt counts the RUN-state wait cycle too, so the fault fires on the
   // MEM_TIMEOUT-th consecutive wait cycle (also covers MEM_TIMEOUT == 1).
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_pc_we       = 1'b1;
      w_ifid_stall  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_stall  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_stall = 1'b0;
      w_timeout     = 1'b0;
      if (reset) begin
         unique case (r_state)
            RUN, MEM_WAIT: begin
               if (w_memwait) begin
                  w_pc_we       = 1'b0;
                  w_ifid_stall  = 1'b1;
                  w_idex_stall  = 1'b1;
                  w_exmem_stall = 1'b1;
                  if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                     w_state_nxt = FAULT;
                     w_wait_nxt  = '0;
                  end else begin
                     w_state_nxt = MEM_WAIT;
                     w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                  end
               end else begin
                  w_state_nxt = RUN;
                  w_wait_nxt  = '0;
                  if (hz.ex_redirect) begin
                     w_ifid_flush = 1'b1;
                     w_idex_flush = 1'b1;
                  end else if (w_loaduse) begin
                     w_pc_we      = 1'b0;
                     w_ifid_stall = 1'b1;
                     w_idex_flush = 1'b1;
                  end
               end
            end
            FAULT: begin
               w_pc_we       = 1'b0;
               w_ifid_stall  = 1'b1;
               w_idex_stall  = 1'b1;
               w_exmem_stall = 1'b1;
               w_timeout     = 1'b1;
            end
            default: begin
               w_state_nxt = RUN;
               w_wait_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (!w_pc_we)
            r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
         if (w_idex_flush)
            r_flush_events <= r_flush_events + CNT_WIDTH'(1);
      end
   end

   assign hz.pc_write_en  = w_pc_we;
   assign hz.ifid_stall   = w_ifid_stall;
   assign hz.ifid_flush   = w_ifid_flush;
   assign hz.idex_stall   = w_idex_stall;
   assign hz.idex_flush   = w_idex_flush;
   assign hz.exmem_stall  = w_exmem_stall;
   assign hz.mem_timeout  = w_timeout;
   assign hz.stall_cycles = r_stall_cycles;
   assign hz.flush_events = r_flush_events;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table of combinational cases plus
// hand-written wait/timeout/async-reset/counter-wrap sequences.
module tb_hazard_ctrl;
   localparam int unsigned RW  = 5;
   localparam int unsigned CW  = 4;
   localparam int unsigned TMO = 4;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   hazard_ctrl_if #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) hz ();

   hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_write_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, mem_timeout}
   localparam logic [6:0] O_IDLE  = 7'b1000000;
   localparam logic [6:0] O_LU    = 7'b0100100;
   localparam logic [6:0] O_REDIR = 7'b1010100;
   localparam logic [6:0] O_WAIT  = 7'b0101010;
   localparam logic [6:0] O_FAULT = 7'b0101011;

   typedef struct {
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic          u1;
      logic          u2;
      logic [RW-1:0] rd;
      logic          mr;
      logic          redir;
      logic          req;
      logic          rdy;
      logic [6:0]    exp;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                               input logic u1, input logic u2, input logic [RW-1:0] rd,
                               input logic mr, input logic redir, input logic req,
                               input logic rdy, input logic [6:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.mr = mr; v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   function automatic logic [6:0] outs();
      return {hz.pc_write_en, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
              hz.idex_flush, hz.exmem_stall, hz.mem_timeout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      hz.id_rs1      = v.rs1;
      hz.id_rs2      = v.rs2;
      hz.id_uses_rs1 = v.u1;
      hz.id_uses_rs2 = v.u2;
      hz.ex_rd       = v.rd;
      hz.ex_mem_read = v.mr;
      hz.ex_redirect = v.redir;
      hz.mem_req     = v.req;
      hz.mem_ready   = v.rdy;
   endtask

   task automatic idle_in();
      drive(mk('0, '0, 0, 0, '0, 0, 0, 0, 0, O_IDLE));
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_in();
      reset = 1'b0;
      #1;
      chk("reset_outs", 32'(outs()), 32'(O_IDLE));
      chk("reset_stall_cnt", 32'(hz.stall_cycles), 0);
      chk("reset_flush_cnt", 32'(hz.flush_events), 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      idle_in();

      //          rs1 rs2 u1 u2 rd mr rd req rdy exp
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
      tbl[1]  = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, O_LU);
      tbl[2]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, O_IDLE);
      tbl[3]  = mk(3, 7, 1, 1, 7, 1, 0, 0, 0, O_LU);
      tbl[4]  = mk(3, 7, 1, 0, 7, 1, 0, 0, 0, O_IDLE);
      tbl[5]  = mk(5, 0, 1, 0, 5, 0, 0, 0, 0, O_IDLE);
      tbl[6]  = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, O_REDIR);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_WAIT);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_IDLE);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_WAIT);
      tbl[10] = mk(9, 0, 1, 0, 9, 1, 0, 1, 0, O_WAIT);
      tbl[11] = mk(9, 0, 1, 0, 9, 1, 0, 1, 1, O_LU);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_REDIR);

      do_reset();
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      end
      @(posedge clk);
      #1;
      chk("tbl_stall_cnt", 32'(hz.stall_cycles), 6);
      chk("tbl_flush_cnt", 32'(hz.flush_events), 5);

      // Single load-use bubble then clear
      do_reset();
      @(negedge clk);
      drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, O_LU));
      #1;
      chk("lu_outs", 32'(outs()), 32'(O_LU));
      @(negedge clk);
      idle_in();
      #1;
      chk("lu_clear_outs", 32'(outs()), 32'(O_IDLE));
      chk("lu_stall_cnt", 32'(hz.stall_cycles), 1);
      chk("lu_flush_cnt", 32'(hz.flush_events), 1);

      // Memory wait with redirect held throughout
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_WAIT));
         #1;
         chk($sformatf("wait_c%0d", k), 32'(outs()), 32'(O_WAIT));
      end
      @(negedge clk);
      hz.mem_ready = 1'b1;
      #1;
      chk("wait_ready_outs", 32'(outs()), 32'(O_REDIR));
      chk("wait_stall_cnt", 32'(hz.stall_cycles), 3);
      @(negedge clk);
      idle_in();
      #1;
      chk("wait_flush_cnt", 32'(hz.flush_events), 1);

      // Timeout into sticky FAULT
      do_reset();
      for (int k = 0; k < int'(TMO); k++) begin
         @(negedge clk);
         drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_WAIT));
         #1;
         chk($sformatf("tmo_wait%0d", k), 32'(outs()), 32'(O_WAIT));
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(mk(5, 0, 1, 0, 5, 1, 1, 1, 1, O_FAULT));
         #1;
         chk($sformatf("fault_outs%0d", k), 32'(outs()), 32'(O_FAULT));
      end
      @(posedge clk);
      #1;
      chk("fault_stall_cnt", 32'(hz.stall_cycles), 6);
      chk("fault_flush_cnt", 32'(hz.flush_events), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("fault_reset_outs", 32'(outs()), 32'(O_IDLE));
      chk("fault_reset_cnt", 32'(hz.stall_cycles), 0);
      @(negedge clk);
      reset = 1'b1;

      // Async reset between edges while in MEM_WAIT
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_WAIT));
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_outs", 32'(outs()), 32'(O_IDLE));
      chk("async_stall_cnt", 32'(hz.stall_cycles), 0);
      @(negedge clk);
      reset = 1'b1;
      hz.mem_ready = 1'b1;
      #1;
      chk("async_ready_nowait", 32'(outs()), 32'(O_IDLE));
      for (int k = 0; k < int'(TMO) - 1; k++) begin
         @(negedge clk);
         hz.mem_ready = 1'b0;
         #1;
         chk($sformatf("async_rewait%0d", k), 32'(outs()), 32'(O_WAIT));
      end
      @(negedge clk);
      idle_in();
      #1;
      chk("async_no_fault", 32'(outs()), 32'(O_IDLE));

      // 4-bit counter wrap after 17 bubbles
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         drive(mk(2, 0, 1, 0, 2, 1, 0, 0, 0, O_LU));
      end
      @(negedge clk);
      idle_in();
      #1;
      chk("wrap_flush_cnt", 32'(hz.flush_events), 1);
      chk("wrap_stall_cnt", 32'(hz.stall_cycles), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and control unit for the 5-stage RISC-V core. It drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable. It detects load-use hazards, EX-stage redirects and data-memory wait states. It also keeps stall/flush performance counters and a sticky memory-timeout fault.

Parameters:
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, performance counter width
MEM_TIMEOUT, 256, max consecutive MEM_WAIT cycles before fault (>=1)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
id_rs1  input  REG_ADDR_WIDTH  rs1 of instruction in ID
id_rs2  input  REG_ADDR_WIDTH  rs2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  REG_ADDR_WIDTH  rd of instruction in EX
ex_mem_read  input  1  instruction in EX is a load
ex_redirect  input  1  EX resolved taken branch/jump or mispredict
mem_req  input  1  MEM stage has an outstanding data-memory access
mem_ready  input  1  data memory completes the access this cycle
pc_write_en  output  1  PC may update
ifid_stall  output  1  hold IF/ID
ifid_flush  output  1  load NOP into IF/ID
idex_stall  output  1  hold ID/EX
idex_flush  output  1  load NOP bubble into ID/EX
exmem_stall  output  1  hold EX/MEM
mem_timeout  output  1  sticky fault flag
stall_cycles  output  CNT_WIDTH  cycles with pc_write_en=0
flush_events  output  CNT_WIDTH  cycles with idex_flush=1

Behaviour:
- State register: RUN, MEM_WAIT, FAULT. Reset (reset=0, async) -> RUN, all counters 0, wait_cnt 0, mem_timeout 0.
- Control outputs are combinational from the current state and inputs. Same-cycle response, zero latency.
- While reset is asserted: pc_write_en=1, all stall/flush outputs 0.
- Hazard terms:
  - memwait = mem_req & ~mem_ready.
  - loaduse = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in RUN and MEM_WAIT: memwait > ex_redirect > loaduse > none.
  - memwait: pc_write_en=0; ifid_stall=idex_stall=exmem_stall=1; both flush outputs 0. A concurrent redirect is ignored; the branch stays held in EX and reasserts after the wait.
  - ex_redirect: pc_write_en=1, ifid_flush=1, idex_flush=1, all stalls 0. This overrides loaduse.
  - loaduse: pc_write_en=0, ifid_stall=1, idex_flush=1 (one bubble), idex_stall=0, exmem_stall=0. The bubble clears the condition next cycle, so the stall is exactly 1 cycle.
  - none: pc_write_en=1, all others 0.
- Transitions:
  - RUN -> MEM_WAIT when memwait.
  - MEM_WAIT -> RUN when ~memwait; mem_ready, or mem_req dropping, releases the stall in that same cycle.
  - MEM_WAIT -> FAULT when memwait and wait_cnt==MEM_TIMEOUT-1.
  - FAULT is sticky until reset.
- wait_cnt counts consecutive memwait cycles. It is 0 in RUN and increments each MEM_WAIT cycle with memwait. mem_req=1 with mem_ready=1 in the first cycle causes no wait.
- FAULT: mem_timeout=1, pc_write_en=0, all three stalls=1, flushes=0. All inputs are ignored.
- Counters:
  - stall_cycles += 1 on every clock with pc_write_en=0, FAULT included.
  - flush_events += 1 on every clock with idex_flush=1.
  - Both wrap modulo 2^CNT_WIDTH. Both are registered, so the value reflects the prior cycle's events.
- Reset mid-MEM_WAIT or in FAULT returns to RUN immediately, asynchronously, and clears the counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle, then ex_mem_read=0 -> that cycle pc_write_en=0, ifid_stall=1, idex_flush=1. Next cycle all clear, stall_cycles=1, flush_events=1. Same with ex_rd=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 with loaduse true -> ifid_flush=1, idex_flush=1, pc_write_en=1, ifid_stall=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 with ex_redirect=1 throughout -> 3 cycles all stalls=1 and flushes=0. On the ready cycle stalls drop and the flushes assert. stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> FAULT entered after 4th wait cycle, mem_timeout=1. It stays set after mem_ready=1 and clears only on reset=0.
- Async reset mid-wait: drop reset between clock edges during MEM_WAIT -> outputs return to the idle values immediately (pc_write_en=1, all stalls/flushes 0), counters 0, state RUN.
- Counter wrap: CNT_WIDTH=4, 17 load-use bubbles -> flush_events=1.
